display_scan: RTL and testbench
===============================

# display_scan

Time-multiplexed 4-digit scan controller that sits directly upstream of the 7-segment decoder. It holds a 16-bit display value and double-buffers updates so a new value never appears in the middle of a scan frame. Each clock it presents one nibble to the decoder's hex inputs (bit 3 to SW3, bit 0 to SW0) and drives the matching active-low digit enable. It also applies ghost-suppression guard time and optional leading-zero blanking.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; must be > GUARD+1.
- GUARD, 2: cycles at the start of each slot with all digits disabled.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- VALUE  in  16  display value; nibble k drives digit k, with digit 0 the rightmost.
- LOAD  in  1  single-cycle strobe that captures VALUE into the shadow register.
- BLANK_LZ  in  1  when 1, leading zeros are blanked; sampled every cycle.
- HEX  out  4  nibble for the current digit, to decoder SW3..SW0.
- AN  out  4  digit enables, active-low; bit k enables digit k.
- FRAME  out  1  one-cycle pulse on the last cycle of digit 3's slot.
- PENDING  out  1  a loaded value is waiting for transfer.

## Operation
- Registers:
  - cnt: 0..CLK_DIV-1.
  - dig: 0..3.
  - shadow, active: 16 bits each.
  - pend: 1 bit.
- All outputs are registered.
- Prescaler:
  - cnt increments every cycle.
  - tick = (cnt == CLK_DIV-1).
  - On tick, cnt returns to 0 and dig advances 0→1→2→3→0 (wraps).
- LOAD:
  - shadow <= VALUE.
  - pend <= 1.
  - A later LOAD before transfer overwrites shadow; last one wins.
- Transfer:
  - Happens on tick with dig == 3 and pend == 1.
  - active <= shadow, pend <= 0.
- Simultaneous LOAD and transfer edge: VALUE bypasses straight to active, shadow <= VALUE, and pend ends at 0.
- HEX = active[4*dig+3 : 4*dig] for the slot in progress, using the post-transfer active in slot 0.
- Digit enable:
  - AN[dig] = 0 only when GUARD <= cnt <= CLK_DIV-1 and the digit is not blanked.
  - All other AN bits are 1 at all times.
- Leading-zero blanking, with BLANK_LZ = 1:
  - Digit k (k = 3..1) is blanked when nibble k and every higher nibble of active are zero.
  - Digit 0 is never blanked, so value 0 shows "0".
- FRAME = 1 exactly when dig == 3 and cnt == CLK_DIV-1.

## Timing
- Reset values (the cycle after RST is sampled high):
  - cnt=0, dig=0.
  - shadow=0, active=0, pend=0.
  - HEX=0, AN=4'b1111, FRAME=0, PENDING=0.
- RST mid-slot or mid-frame aborts the scan immediately; the pending value is lost.
- Slot length is exactly CLK_DIV cycles; frame length is 4·CLK_DIV cycles.
- HEX and dig change on the same edge, which is the first cycle of a slot with AN=1111.
- AN goes low GUARD cycles later, so HEX is stable for GUARD cycles before any digit lights.
- LOAD to display: the value appears in slot 0 of the next frame.
  - Worst-case latency is 4·CLK_DIV + GUARD cycles.
- PENDING:
  - Rises on the edge after LOAD.
  - Falls on the transfer edge.
- A BLANK_LZ change takes effect on AN the next cycle.

## Structure
- Shared package display_pkg holds:
  - DIGITS = 4.
  - AN_OFF = 4'b1111.
  - NIBBLE_W = 4.
  - The digit-index type (2 bits), shared with the decoder-side top level.
- One sub-module, scan_tick_gen: parameterised prescaler providing cnt, tick and the guard-window flag.
- The shadow/active buffer, dig counter and blanking logic stay in display_scan.

## Test plan
All scenarios use CLK_DIV=8, GUARD=2.
- **Reset:** assert RST 3 cycles, then release.
  - During reset: AN=1111, HEX=0, FRAME=0.
  - After release: AN=1110 at cnt=2, and HEX=0 throughout slot 0.
- **Basic update:** LOAD VALUE=16'h1A2F mid-frame.
  - PENDING=1; display is unchanged until the wrap.
  - Next frame shows HEX F,2,A,1 with AN 1110,1101,1011,0111, each low for 6 of 8 cycles.
- **Leading-zero blanking:** VALUE=16'h0042, BLANK_LZ=1.
  - Digits 3 and 2: AN bit held 1 for the whole slot.
  - Digits 1 and 0 show 4 and 2.
  - Set BLANK_LZ=0: all four lit, showing 0,0,4,2.
- **Coincident LOAD:** LOAD 16'h00FF on the FRAME cycle.
  - Slot 0 immediately shows F.
  - PENDING stays 0.
- **Double LOAD:** 16'h1111 then 16'h2222 in the same frame.
  - Only 2222 is displayed.
  - FRAME pulses once per 32 cycles.
- **Reset mid-operation:** RST during slot 2 with a pending load.
  - Outputs return to reset values next cycle.
  - The pending value is never displayed.

Source files
------------

// File: rtl/display_pkg.sv
// Constants and types shared by the display scan controller and the decoder-side top level.
package display_pkg;
  localparam int          DIGITS   = 4;
  localparam int          NIBBLE_W = 4;
  localparam logic [3:0]  AN_OFF   = 4'b1111;

  typedef logic [1:0] digit_t;
endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..CLK_DIV-1 and flags the slot boundary and the lit window.
module scan_tick_gen #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2,
  parameter int CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          tick,
  output logic          window_next
);

  logic [CW-1:0] cnt_next;

  always_comb begin
    tick        = (cnt == CW'(CLK_DIV - 1));
    cnt_next    = tick ? '0 : cnt + CW'(1);
    // Lookahead so the registered digit enables line up with the count they belong to.
    window_next = (cnt_next >= CW'(GUARD));
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit time-multiplexed scan controller with double-buffered value, guard time
// and optional leading-zero blanking. All outputs are registered from next-state values.
module display_scan
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VALUE,
  input  logic        LOAD,
  input  logic        BLANK_LZ,
  output logic [3:0]  HEX,
  output logic [3:0]  AN,
  output logic        FRAME,
  output logic        PENDING
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  logic          window_next;

  digit_t        dig, dig_next;
  logic [15:0]   shadow, shadow_next;
  logic [15:0]   active, active_next;
  logic          pend, pend_next;
  logic          transfer;
  logic [DIGITS-1:0] blank;
  logic [3:0]    hex_next;
  logic [3:0]    an_next;
  logic          frame_next;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .GUARD   (GUARD),
    .CW      (CW)
  ) u_tick (
    .clk         (CLK),
    .rst         (RST),
    .cnt         (cnt),
    .tick        (tick),
    .window_next (window_next)
  );

  // LOAD is a one-cycle strobe with no back-pressure; the last strobe before the
  // frame wrap wins, and a strobe on the wrap edge goes straight to the display.
  always_comb begin
    transfer    = tick && (dig == digit_t'(3)) && (pend || LOAD);
    dig_next    = tick ? dig + digit_t'(1) : dig;
    shadow_next = LOAD ? VALUE : shadow;
    active_next = transfer ? (LOAD ? VALUE : shadow) : active;
    pend_next   = transfer ? 1'b0 : (LOAD ? 1'b1 : pend);
  end

  // Blanking cascades down from the top digit; digit 0 always shows.
  always_comb begin
    blank    = '0;
    blank[3] = BLANK_LZ && (active_next[15:12] == 4'h0);
    blank[2] = blank[3] && (active_next[11:8] == 4'h0);
    blank[1] = blank[2] && (active_next[7:4] == 4'h0);
  end

  always_comb begin
    hex_next = active_next[NIBBLE_W*dig_next +: NIBBLE_W];
    an_next  = AN_OFF;
    if (window_next && !blank[dig_next]) an_next[dig_next] = 1'b0;
    // Next cycle is the last of digit 3's slot exactly when the count is one short of it now.
    frame_next = (dig == digit_t'(3)) && (cnt == CW'(CLK_DIV - 2));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dig     <= '0;
      shadow  <= '0;
      active  <= '0;
      pend    <= 1'b0;
      HEX     <= '0;
      AN      <= AN_OFF;
      FRAME   <= 1'b0;
      PENDING <= 1'b0;
    end else begin
      dig     <= dig_next;
      shadow  <= shadow_next;
      active  <= active_next;
      pend    <= pend_next;
      HEX     <= hex_next;
      AN      <= an_next;
      FRAME   <= frame_next;
      PENDING <= pend_next;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with CLK_DIV=8, GUARD=2; frame position is tracked
// by the bench as pos = 8*digit + count.
module tb_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        frame;
  logic        pending;

  int n_checks;
  int n_fail;
  int pos;

  display_scan #(.CLK_DIV(8), .GUARD(2)) dut (
    .CLK      (clk),
    .RST      (rst),
    .VALUE    (value),
    .LOAD     (load),
    .BLANK_LZ (blank_lz),
    .HEX      (hex),
    .AN       (an),
    .FRAME    (frame),
    .PENDING  (pending)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 32;
  endtask

  task automatic advance_to(input int p);
    while (pos != p) step();
  endtask

  // Walks one full frame starting at pos 0 and ends at pos 0 of the next frame.
  task automatic check_frame(input logic [15:0] val, input logic [3:0] lit, input logic pend_exp);
    logic [3:0] exp_an;
    int d;
    int c;
    for (int i = 0; i < 32; i++) begin
      d = i / 8;
      c = i % 8;
      exp_an = 4'hF;
      if (c >= 2 && lit[d]) exp_an[d] = 1'b0;
      chk("hex", {12'h0, hex}, {12'h0, val[4*d +: 4]});
      chk("an", {12'h0, an}, {12'h0, exp_an});
      chk("frame", {15'h0, frame}, {15'h0, (i == 31)});
      chk("pending", {15'h0, pending}, {15'h0, pend_exp});
      step();
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pos      = 0;
    rst      = 1'b1;
    value    = 16'h0;
    load     = 1'b0;
    blank_lz = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_an", {12'h0, an}, 16'h000F);
      chk("rst_hex", {12'h0, hex}, 16'h0000);
      chk("rst_frame", {15'h0, frame}, 16'h0000);
      chk("rst_pending", {15'h0, pending}, 16'h0000);
    end
    rst = 1'b0;
    pos = 0;
    check_frame(16'h0000, 4'b1111, 1'b0);

    // Zero with blanking: only digit 0 lights
    blank_lz = 1'b1;
    step();
    blank_lz = 1'b0;
    advance_to(0);
    blank_lz = 1'b1;
    check_frame(16'h0000, 4'b0001, 1'b0);
    blank_lz = 1'b0;
    advance_to(0);

    // Basic update mid-frame
    advance_to(12);
    pulse_load(16'h1A2F);
    chk("upd_pending", {15'h0, pending}, 16'h0001);
    chk("upd_hex_old", {12'h0, hex}, 16'h0000);
    chk("upd_an_old", {12'h0, an}, 16'h000D);
    advance_to(31);
    chk("upd_frame", {15'h0, frame}, 16'h0001);
    chk("upd_pending_hold", {15'h0, pending}, 16'h0001);
    step();
    check_frame(16'h1A2F, 4'b1111, 1'b0);

    // Leading-zero blanking on 0042
    blank_lz = 1'b1;
    advance_to(5);
    pulse_load(16'h0042);
    chk("lz_pending", {15'h0, pending}, 16'h0001);
    advance_to(0);
    check_frame(16'h0042, 4'b0011, 1'b0);
    blank_lz = 1'b0;
    check_frame(16'h0042, 4'b1111, 1'b0);

    // LOAD coincident with the frame wrap
    advance_to(31);
    chk("co_frame", {15'h0, frame}, 16'h0001);
    pulse_load(16'h00FF);
    chk("co_pending", {15'h0, pending}, 16'h0000);
    check_frame(16'h00FF, 4'b1111, 1'b0);

    // Two loads in one frame: last wins
    advance_to(3);
    pulse_load(16'h1111);
    chk("dbl_pending1", {15'h0, pending}, 16'h0001);
    advance_to(20);
    pulse_load(16'h2222);
    chk("dbl_pending2", {15'h0, pending}, 16'h0001);
    chk("dbl_hex_old", {12'h0, hex}, 16'h0000);
    advance_to(0);
    check_frame(16'h2222, 4'b1111, 1'b0);

    // Reset during slot 2 with a load pending
    advance_to(5);
    pulse_load(16'h3333);
    advance_to(18);
    chk("mid_pending", {15'h0, pending}, 16'h0001);
    rst = 1'b1;
    step();
    chk("mid_rst_an", {12'h0, an}, 16'h000F);
    chk("mid_rst_hex", {12'h0, hex}, 16'h0000);
    chk("mid_rst_frame", {15'h0, frame}, 16'h0000);
    chk("mid_rst_pending", {15'h0, pending}, 16'h0000);
    rst = 1'b0;
    pos = 0;
    check_frame(16'h0000, 4'b1111, 1'b0);
    check_frame(16'h0000, 4'b1111, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
